// File: rtl/hazard_sched_if.sv
// Hazard-unit bundle: pipeline register addresses and control bits in,
// forwarding selects plus stall/flush/divider status out.
interface hazard_sched_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rsD, rtD;
  logic              branchD;
  logic [REG_AW-1:0] rsE, rtE, writeregE;
  logic              regwriteE, memtoregE, div_startE;
  logic [REG_AW-1:0] writeregM;
  logic              regwriteM, memtoregM, exceptM;
  logic [REG_AW-1:0] writeregW;
  logic              regwriteW;
  logic              i_stall, d_stall;

  logic              forwardaD, forwardbD;
  logic [1:0]        forwardaE, forwardbE;
  logic              stallF, stallD, stallE, stallM, stallW;
  logic              flushD, flushE, flushM, flushW;
  logic              div_busy, div_done;

  // Pipeline datapath side: drives stage information, consumes controls.
  modport master (
    output rsD, rtD, branchD,
    output rsE, rtE, writeregE, regwriteE, memtoregE, div_startE,
    output writeregM, regwriteM, memtoregM, exceptM,
    output writeregW, regwriteW,
    output i_stall, d_stall,
    input  forwardaD, forwardbD, forwardaE, forwardbE,
    input  stallF, stallD, stallE, stallM, stallW,
    input  flushD, flushE, flushM, flushW,
    input  div_busy, div_done
  );

  modport slave (
    input  rsD, rtD, branchD,
    input  rsE, rtE, writeregE, regwriteE, memtoregE, div_startE,
    input  writeregM, regwriteM, memtoregM, exceptM,
    input  writeregW, regwriteW,
    input  i_stall, d_stall,
    output forwardaD, forwardbD, forwardaE, forwardbE,
    output stallF, stallD, stallE, stallM, stallW,
    output flushD, flushE, flushM, flushW,
    output div_busy, div_done
  );
endinterface

// File: rtl/hazard_sched.sv
// Hazard/scheduling unit for a 5-stage MIPS pipeline: forwarding, load-use and
// branch interlocks, multi-cycle divider sequencing, memory freeze, M-stage exceptions.
module hazard_sched #(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  hazard_sched_if.slave hz
);

  if (DIV_CYCLES < 2 || DIV_CYCLES > 255) begin : g_bad_div_cycles
    $error("hazard_sched: DIV_CYCLES must be within 2..255");
  end
  if ((2 ** CNT_W) <= DIV_CYCLES) begin : g_bad_cnt_w
    $error("hazard_sched: CNT_W too narrow for DIV_CYCLES");
  end

  localparam logic [REG_AW-1:0] REG_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic memstall, lwstall, branchstall, divstall, exc_flush;

  // M result has priority over W because it is the younger write.
  function automatic logic [1:0] fwd_sel_e(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] wreg_m,
    input logic              rw_m,
    input logic [REG_AW-1:0] wreg_w,
    input logic              rw_w
  );
    if (src != REG_ZERO && rw_m && src == wreg_m)      return 2'b10;
    else if (src != REG_ZERO && rw_w && src == wreg_w) return 2'b01;
    else                                               return 2'b00;
  endfunction

  always_comb begin
    hz.forwardaE = fwd_sel_e(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
    hz.forwardbE = fwd_sel_e(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
    hz.forwardaD = (hz.rsD != REG_ZERO) && hz.regwriteM && (hz.rsD == hz.writeregM);
    hz.forwardbD = (hz.rtD != REG_ZERO) && hz.regwriteM && (hz.rtD == hz.writeregM);
  end

  always_comb begin
    memstall = hz.i_stall || hz.d_stall;
    lwstall  = hz.memtoregE && (hz.rtE != REG_ZERO) &&
               ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
    branchstall = hz.branchD && (
        (hz.regwriteE && (hz.writeregE != REG_ZERO) &&
         ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
        (hz.memtoregM && (hz.writeregM != REG_ZERO) &&
         ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
    // A frozen pipeline holds the exception in M until memory is ready again.
    exc_flush = hz.exceptM && !memstall;
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Divider next-state: memstall freezes everything, then exceptions abort.
  always_comb begin
    // NOTE: defaulting every comb output first guarantees no latch is inferred
    // on paths that leave a signal unassigned.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (hz.div_startE && !memstall && !hz.exceptM) begin
          state_d = S_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      S_BUSY: begin
        if (memstall) begin
          state_d = S_BUSY;
        end else if (hz.exceptM) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Divider outputs; DONE releases E so the div leaves on that edge.
  always_comb begin
    hz.div_busy = (state_q == S_BUSY);
    hz.div_done = (state_q == S_DONE) && !hz.exceptM;
    divstall    = ((state_q == S_IDLE) && hz.div_startE) || (state_q == S_BUSY);
  end

  always_comb begin
    hz.stallM = memstall;
    hz.stallW = memstall;
    hz.flushD = exc_flush;
    hz.flushM = exc_flush;
    hz.flushW = exc_flush;
    if (exc_flush) begin
      hz.stallF = 1'b0;
      hz.stallD = 1'b0;
      hz.stallE = 1'b0;
      hz.flushE = 1'b1;
    end else begin
      hz.stallF = lwstall || branchstall || divstall || memstall;
      hz.stallD = lwstall || branchstall || divstall || memstall;
      hz.stallE = divstall || memstall;
      // Bubble only when E really advances, or it would overwrite a held op.
      hz.flushE = (lwstall || branchstall) && !divstall && !memstall;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: a combinational vector table plus
// clocked sequences for the divider, memory freeze, exceptions and reset.
module tb_hazard_sched;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic rst;

  hazard_sched_if #(.REG_AW(REG_AW)) hz();

  hazard_sched #(
    .REG_AW(REG_AW),
    .DIV_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rsD, rtD;
    logic       branchD;
    logic [4:0] rsE, rtE, writeregE;
    logic       regwriteE, memtoregE;
    logic [4:0] writeregM;
    logic       regwriteM, memtoregM;
    logic [4:0] writeregW;
    logic       regwriteW, i_stall, d_stall;
  } ins_t;

  typedef struct packed {
    logic       faD, fbD;
    logic [1:0] faE, fbE;
    logic       sF, sD, sE, sM, sW;
    logic       fD, fE, fM, fW;
    logic       busy, done;
  } outs_t;

  typedef struct {
    string name;
    ins_t  i;
    outs_t o;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (faD fbD faE fbE sF sD sE sM sW fD fE fM fW busy done)",
               name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input ins_t i);
    hz.rsD = i.rsD;             hz.rtD = i.rtD;             hz.branchD = i.branchD;
    hz.rsE = i.rsE;             hz.rtE = i.rtE;             hz.writeregE = i.writeregE;
    hz.regwriteE = i.regwriteE; hz.memtoregE = i.memtoregE;
    hz.writeregM = i.writeregM; hz.regwriteM = i.regwriteM; hz.memtoregM = i.memtoregM;
    hz.writeregW = i.writeregW; hz.regwriteW = i.regwriteW;
    hz.i_stall = i.i_stall;     hz.d_stall = i.d_stall;
  endtask

  function automatic outs_t read_outs();
    outs_t o;
    o.faD = hz.forwardaD; o.fbD = hz.forwardbD;
    o.faE = hz.forwardaE; o.fbE = hz.forwardbE;
    o.sF = hz.stallF; o.sD = hz.stallD; o.sE = hz.stallE; o.sM = hz.stallM; o.sW = hz.stallW;
    o.fD = hz.flushD; o.fE = hz.flushE; o.fM = hz.flushM; o.fW = hz.flushW;
    o.busy = hz.div_busy; o.done = hz.div_done;
    return o;
  endfunction

  task automatic check_outs(input string name, input outs_t exp);
    check(name, read_outs(), exp);
  endtask

  task automatic zero_inputs();
    apply('0);
    hz.exceptM    = 1'b0;
    hz.div_startE = 1'b0;
  endtask

  // Divide with optional d_stall window [st_lo, st_hi]; quotient due at cycle done_c.
  task automatic run_div(input string tag, input int st_lo, input int st_hi, input int done_c);
    outs_t e;
    for (int c = 0; c <= done_c + 1; c++) begin
      zero_inputs();
      hz.d_stall    = (c >= st_lo) && (c <= st_hi);
      hz.div_startE = (c <= done_c);
      #1;
      e      = '0;
      e.busy = (c >= 1) && (c < done_c);
      e.done = (c == done_c);
      e.sM   = hz.d_stall;
      e.sW   = hz.d_stall;
      e.sE   = (c < done_c) || hz.d_stall;
      e.sF   = e.sE;
      e.sD   = e.sE;
      check_outs($sformatf("%s_c%0d", tag, c), e);
      step();
    end
  endtask

  // Exception raised in the second BUSY cycle, frozen for mem_cycles by d_stall.
  task automatic run_exc(input string tag, input int mem_cycles);
    outs_t e;
    int    fc;
    fc = 2 + mem_cycles;
    for (int c = 0; c <= fc + 4; c++) begin
      zero_inputs();
      hz.div_startE = (c <= fc);
      hz.exceptM    = (c >= 2) && (c <= fc);
      hz.d_stall    = (c >= 2) && (c < fc);
      #1;
      e = '0;
      if (c <= 1) begin
        e.busy = (c == 1);
        e.sF = 1'b1; e.sD = 1'b1; e.sE = 1'b1;
      end else if (c < fc) begin
        e.busy = 1'b1;
        e.sF = 1'b1; e.sD = 1'b1; e.sE = 1'b1; e.sM = 1'b1; e.sW = 1'b1;
      end else if (c == fc) begin
        e.busy = 1'b1;
        e.fD = 1'b1; e.fE = 1'b1; e.fM = 1'b1; e.fW = 1'b1;
      end
      check_outs($sformatf("%s_c%0d", tag, c), e);
      step();
    end
  endtask

  initial begin
    vecs[0]  = '{name: "idle_zero",      i: '{default: '0}, o: '{default: '0}};
    vecs[1]  = '{name: "fwdE_M_over_W",
                 i: '{default: '0, rsE: 5'd8, regwriteM: 1'b1, writeregM: 5'd8, regwriteW: 1'b1, writeregW: 5'd8},
                 o: '{default: '0, faE: 2'b10}};
    vecs[2]  = '{name: "fwdE_W",
                 i: '{default: '0, rsE: 5'd8, writeregM: 5'd8, regwriteW: 1'b1, writeregW: 5'd8},
                 o: '{default: '0, faE: 2'b01}};
    vecs[3]  = '{name: "fwdE_r0",
                 i: '{default: '0, regwriteM: 1'b1, regwriteW: 1'b1},
                 o: '{default: '0}};
    vecs[4]  = '{name: "fwdbE_M",
                 i: '{default: '0, rtE: 5'd3, regwriteM: 1'b1, writeregM: 5'd3, regwriteW: 1'b1, writeregW: 5'd3},
                 o: '{default: '0, fbE: 2'b10}};
    vecs[5]  = '{name: "fwdbD_only",
                 i: '{default: '0, rsD: 5'd4, rtD: 5'd5, regwriteM: 1'b1, writeregM: 5'd5},
                 o: '{default: '0, fbD: 1'b1}};
    vecs[6]  = '{name: "fwdD_both",
                 i: '{default: '0, rsD: 5'd6, rtD: 5'd6, regwriteM: 1'b1, writeregM: 5'd6},
                 o: '{default: '0, faD: 1'b1, fbD: 1'b1}};
    vecs[7]  = '{name: "loaduse_rs",
                 i: '{default: '0, memtoregE: 1'b1, rtE: 5'd9, rsD: 5'd9},
                 o: '{default: '0, sF: 1'b1, sD: 1'b1, fE: 1'b1}};
    vecs[8]  = '{name: "loaduse_r0",
                 i: '{default: '0, memtoregE: 1'b1},
                 o: '{default: '0}};
    vecs[9]  = '{name: "loaduse_rt",
                 i: '{default: '0, memtoregE: 1'b1, rtE: 5'd7, rtD: 5'd7, rsD: 5'd1},
                 o: '{default: '0, sF: 1'b1, sD: 1'b1, fE: 1'b1}};
    vecs[10] = '{name: "branch_aluE",
                 i: '{default: '0, branchD: 1'b1, rsD: 5'd10, regwriteE: 1'b1, writeregE: 5'd10},
                 o: '{default: '0, sF: 1'b1, sD: 1'b1, fE: 1'b1}};
    vecs[11] = '{name: "branch_loadM",
                 i: '{default: '0, branchD: 1'b1, rtD: 5'd11, memtoregM: 1'b1, regwriteM: 1'b1, writeregM: 5'd11},
                 o: '{default: '0, fbD: 1'b1, sF: 1'b1, sD: 1'b1, fE: 1'b1}};
    vecs[12] = '{name: "nobranch_aluE",
                 i: '{default: '0, rsD: 5'd10, regwriteE: 1'b1, writeregE: 5'd10},
                 o: '{default: '0}};
    vecs[13] = '{name: "branch_r0",
                 i: '{default: '0, branchD: 1'b1, regwriteE: 1'b1},
                 o: '{default: '0}};
    vecs[14] = '{name: "imem_wait",
                 i: '{default: '0, i_stall: 1'b1},
                 o: '{default: '0, sF: 1'b1, sD: 1'b1, sE: 1'b1, sM: 1'b1, sW: 1'b1}};
    vecs[15] = '{name: "loaduse_dmem_wait",
                 i: '{default: '0, memtoregE: 1'b1, rtE: 5'd9, rsD: 5'd9, d_stall: 1'b1},
                 o: '{default: '0, sF: 1'b1, sD: 1'b1, sE: 1'b1, sM: 1'b1, sW: 1'b1}};
    vecs[16] = '{name: "fwdbE_W",
                 i: '{default: '0, rtE: 5'd12, regwriteW: 1'b1, writeregW: 5'd12, regwriteM: 1'b1, writeregM: 5'd13},
                 o: '{default: '0, fbE: 2'b01}};

    rst = 1'b1;
    zero_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
    check_outs("reset_state", '0);

    for (int k = 0; k < NV; k++) begin
      apply(vecs[k].i);
      #1;
      check_outs(vecs[k].name, vecs[k].o);
      step();
    end

    // Load-use stalls exactly one cycle: next cycle E holds the bubble.
    zero_inputs();
    hz.memtoregE = 1'b1; hz.rtE = 5'd9; hz.rsD = 5'd9;
    #1;
    check_outs("lu_cycle0", '{default: '0, sF: 1'b1, sD: 1'b1, fE: 1'b1});
    step();
    hz.memtoregE = 1'b0; hz.rtE = 5'd0;
    #1;
    check_outs("lu_cycle1", '0);
    step();

    run_div("div", -1, -2, 5);
    run_div("div_dstall", 2, 4, 8);
    run_exc("exc", 0);
    run_exc("exc_dstall", 2);

    // Reset in the middle of a division aborts it without a done pulse.
    for (int c = 0; c < 3; c++) begin
      zero_inputs();
      hz.div_startE = 1'b1;
      #1;
      if (c == 2) check("rst_pre_busy", 17'(hz.div_busy), 17'd1);
      step();
    end
    rst = 1'b1;
    zero_inputs();
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_outs($sformatf("rst_abort_c%0d", c), '0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
